// File: rtl/i2s_capture_pkg.sv
// rtl/i2s_capture_pkg.sv - register map, bit positions and pair type for the I2S ADC capture block
package i2s_capture_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;

  localparam int STAT_EMPTY_BIT  = 16;
  localparam int STAT_FULL_BIT   = 17;
  localparam int STAT_OVF_BIT    = 18;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_FLUSH_BIT  = 1;

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } pair_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush and level count
// A push at full is accepted only when a pop happens in the same cycle; the head is read before the write lands.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [LVL_W-1:0] r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rd];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_adc_capture.sv
// rtl/i2s_adc_capture.sv - oversampled I2S ADC deserializer with stereo-pair FIFO behind an Avalon-MM slave
// Codec clocks are synchronized into clk_clk; only slots that start on an observed LRCK edge are captured.
module i2s_adc_capture
  import i2s_capture_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        aud_bclk,
  input  logic        aud_adclrck,
  input  logic        aud_adcdat,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        irq
);

  localparam int CNT_W = $clog2(SAMPLE_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SAMPLE_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_W - 1);
  localparam logic [LVL_W-1:0] IRQ_LVL  = LVL_W'(FIFO_DEPTH / 2);

  logic [2:0]          r_bclk_sync;
  logic [1:0]          r_lrck_sync;
  logic [1:0]          r_dat_sync;
  logic                r_lrck_q;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic                r_chan;
  logic                r_slot_ok;
  logic [SAMPLE_W-1:0] r_shift;
  logic [SAMPLE_W-1:0] r_left;
  logic                r_left_valid;
  logic                r_enable;
  logic                r_overflow;

  logic                w_brise;
  logic                w_lrck;
  logic                w_dat;
  logic                w_active;
  logic                w_new_slot;
  logic                w_shift_en;
  logic [SAMPLE_W-1:0] w_shift_next;
  logic                w_word_done;
  logic                w_push;
  pair_t               w_pair;
  logic                w_wr_ctrl;
  logic                w_flush;
  logic                w_pop;
  logic [31:0]         w_head;
  logic                w_full;
  logic                w_empty;
  logic [LVL_W-1:0]    w_level;
  logic [31:0]         w_status;
  logic [31:0]         w_rdata_next;
  logic                w_unused_wdata;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_bclk_sync <= '0;
      r_lrck_sync <= '0;
      r_dat_sync  <= '0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[1:0], aud_bclk};
      r_lrck_sync <= {r_lrck_sync[0], aud_adclrck};
      r_dat_sync  <= {r_dat_sync[0], aud_adcdat};
    end
  end

  assign w_brise      = r_bclk_sync[1] & ~r_bclk_sync[2];
  assign w_lrck       = r_lrck_sync[1];
  assign w_dat        = r_dat_sync[1];
  assign w_active     = w_brise & r_enable;
  assign w_new_slot   = (w_lrck != r_lrck_q);
  assign w_shift_en   = w_active & ~w_new_slot & (r_bit_cnt < CNT_MAX);
  assign w_shift_next = SAMPLE_W'({r_shift, w_dat});
  assign w_word_done  = w_shift_en & r_slot_ok & (r_bit_cnt == CNT_LAST);
  assign w_push       = w_word_done & r_chan & r_left_valid;
  assign w_pair       = {16'(r_left), 16'(w_shift_next)};

  // The bit on the LRCK-change edge belongs to the previous slot (I2S one-BCLK delay).
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_lrck_q     <= 1'b0;
      r_bit_cnt    <= '0;
      r_chan       <= 1'b0;
      r_slot_ok    <= 1'b0;
      r_shift      <= '0;
      r_left       <= '0;
      r_left_valid <= 1'b0;
    end else begin
      if (w_brise) r_lrck_q <= w_lrck;
      if (!r_enable) begin
        r_bit_cnt    <= '0;
        r_slot_ok    <= 1'b0;
        r_left_valid <= 1'b0;
      end else if (w_active) begin
        if (w_new_slot) begin
          r_bit_cnt <= '0;
          r_chan    <= w_lrck;
          r_slot_ok <= 1'b1;
        end else if (w_shift_en) begin
          r_shift   <= w_shift_next;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (w_word_done) begin
            r_slot_ok <= 1'b0;
            if (!r_chan) begin
              r_left       <= w_shift_next;
              r_left_valid <= 1'b1;
            end else begin
              r_left_valid <= 1'b0;
            end
          end
        end
      end
      if (w_flush) r_left_valid <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .i_clk   (clk_clk),
    .i_rst   (reset_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdata (w_pair),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign w_wr_ctrl      = avs_write & (avs_address == ADDR_CONTROL);
  assign w_flush        = w_wr_ctrl & avs_writedata[CTRL_FLUSH_BIT];
  assign w_pop          = avs_read & (avs_address == ADDR_DATA) & ~w_empty;
  assign w_unused_wdata = ^avs_writedata[31:2];

  always_comb begin
    w_status                 = '0;
    w_status[LVL_W-1:0]      = w_level;
    w_status[STAT_EMPTY_BIT] = w_empty;
    w_status[STAT_FULL_BIT]  = w_full;
    w_status[STAT_OVF_BIT]   = r_overflow;
  end

  always_comb begin
    w_rdata_next = '0;
    case (avs_address)
      ADDR_DATA:    w_rdata_next = w_empty ? 32'd0 : w_head;
      ADDR_STATUS:  w_rdata_next = w_status;
      ADDR_CONTROL: w_rdata_next = {31'd0, r_enable};
      default:      w_rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_enable     <= 1'b0;
      r_overflow   <= 1'b0;
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_enable <= avs_writedata[CTRL_ENABLE_BIT];
      if (w_flush) begin
        r_overflow <= 1'b0;
      end else if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
      avs_readdata <= avs_read ? w_rdata_next : 32'd0;
      irq          <= r_enable & (w_level >= IRQ_LVL);
    end
  end

endmodule
